// File: rtl/branch_predict_unit.sv
// Branch predict unit: direct-mapped BTB with 2-bit direction counters plus EX-stage resolve/redirect.
// Optional statistics counters are compiled in with `define BP_STATS_EN.
module branch_predict_unit #(
   parameter int unsigned PC_W     = 9,
   parameter int unsigned ENTRIES  = 16,
   parameter logic [1:0]  CTR_INIT = 2'b01
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [PC_W-1:0]   F_PC,
   output logic              Pred_Taken,
   output logic [31:0]       Pred_Target,
   input  logic              Ex_Valid,
   input  logic [PC_W-1:0]   Ex_PC,
   input  logic [31:0]       Imm,
   input  logic              Branch,
   input  logic              Jump,
   input  logic              JumpReg,
   input  logic [31:0]       AluResult,
   input  logic              Ex_Pred_Taken,
   input  logic [31:0]       Ex_Pred_Target,
   output logic [31:0]       PC_Imm,
   output logic [31:0]       PC_Four,
   output logic              Redirect,
   output logic [31:0]       Redirect_PC
`ifdef BP_STATS_EN
   ,
   output logic [31:0]       Stat_Branches,
   output logic [31:0]       Stat_Mispredicts
`endif
);

   localparam int unsigned IDX_W  = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
   localparam int          TAG_W  = int'(PC_W) - int'(IDX_W) - 2;
   localparam int unsigned TAG_WS = (TAG_W > 0) ? TAG_W : 1;

   if (TAG_W < 1) begin : g_tag_w_check
      $error("branch_predict_unit: PC_W too small for ENTRIES, tag width must be at least 1");
   end
   if ((ENTRIES < 2) || (ENTRIES > 256) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_entries_check
      $error("branch_predict_unit: ENTRIES must be a power of two in 2..256");
   end

   // Entry parity guards tag/target/type; a corrupted entry is treated as a miss.
   function automatic logic entry_parity(input logic [TAG_WS-1:0] tag,
                                         input logic [31:0]       target,
                                         input logic              is_jump);
      return ^{tag, target, is_jump};
   endfunction

   function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
      logic [1:0] nxt;
      case ({up, ctr})
         3'b1_00: nxt = 2'b01;
         3'b1_01: nxt = 2'b10;
         3'b1_10: nxt = 2'b11;
         3'b1_11: nxt = 2'b11;
         3'b0_00: nxt = 2'b00;
         3'b0_01: nxt = 2'b00;
         3'b0_10: nxt = 2'b01;
         3'b0_11: nxt = 2'b10;
         default: nxt = CTR_INIT;
      endcase
      return nxt;
   endfunction

   logic              valid_r   [ENTRIES];
   logic [TAG_WS-1:0] tag_r     [ENTRIES];
   logic [31:0]       target_r  [ENTRIES];
   logic              is_jump_r [ENTRIES];
   logic [1:0]        ctr_r     [ENTRIES];
   logic              par_r     [ENTRIES];

   logic [IDX_W-1:0]  f_idx_s;
   logic [TAG_WS-1:0] f_tag_s;
   logic              f_hit_s;
   logic              f_pc_align_unused_s;

   logic [31:0]       ex_pc32_s;
   logic [31:0]       pc_imm_s;
   logic [31:0]       pc_four_s;
   logic              taken_s;
   logic [31:0]       target_s;
   logic              mispredict_s;
   logic [31:0]       redirect_pc_next_s;
   logic              update_s;
   logic [IDX_W-1:0]  ex_idx_s;
   logic [TAG_WS-1:0] ex_tag_s;
   logic              ex_hit_s;

   logic              wr_full_s;
   logic              wr_ctr_en_s;
   logic              wr_is_jump_s;
   logic [1:0]        wr_ctr_s;
   logic [31:0]       wr_target_s;

   logic              redirect_r;
   logic [31:0]       redirect_pc_r;

   assign f_pc_align_unused_s = |F_PC[1:0];

   // Fetch-side lookup: reads registered table contents only, so same-cycle updates are not visible.
   always_comb begin
      f_idx_s = F_PC[IDX_W+1:2];
      f_tag_s = F_PC[PC_W-1:IDX_W+2];
      f_hit_s = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s) &&
                (par_r[f_idx_s] == entry_parity(tag_r[f_idx_s], target_r[f_idx_s], is_jump_r[f_idx_s]));
      if (f_hit_s && (is_jump_r[f_idx_s] || ctr_r[f_idx_s][1])) begin
         Pred_Taken  = 1'b1;
         Pred_Target = target_r[f_idx_s];
      end else begin
         Pred_Taken  = 1'b0;
         Pred_Target = 32'd0;
      end
   end

   // EX-stage outcome, target and mispredict detection.
   always_comb begin
      ex_pc32_s = 32'(Ex_PC);
      pc_imm_s  = ex_pc32_s + Imm;
      pc_four_s = ex_pc32_s + 32'd4;
      taken_s   = (Branch && AluResult[0]) || Jump || JumpReg;
      if (JumpReg) begin
         target_s = {AluResult[31:1], 1'b0} + Imm;
      end else begin
         target_s = pc_imm_s;
      end
      mispredict_s = Ex_Valid && ((taken_s != Ex_Pred_Taken) ||
                                  (taken_s && (target_s != Ex_Pred_Target)));
      if (taken_s) begin
         redirect_pc_next_s = target_s;
      end else begin
         redirect_pc_next_s = pc_four_s;
      end
      update_s = Ex_Valid && (Branch || Jump || JumpReg);
      ex_idx_s = Ex_PC[IDX_W+1:2];
      ex_tag_s = Ex_PC[PC_W-1:IDX_W+2];
      ex_hit_s = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s) &&
                 (par_r[ex_idx_s] == entry_parity(tag_r[ex_idx_s], target_r[ex_idx_s], is_jump_r[ex_idx_s]));
   end

   assign PC_Imm  = pc_imm_s;
   assign PC_Four = pc_four_s;

   // Table write decode: jumps always (re)allocate, branches train on hit or allocate when taken.
   always_comb begin
      wr_full_s    = 1'b0;
      wr_ctr_en_s  = 1'b0;
      wr_is_jump_s = 1'b0;
      wr_ctr_s     = CTR_INIT;
      wr_target_s  = target_s;
      if (update_s) begin
         if (JumpReg || Jump) begin
            wr_full_s    = 1'b1;
            wr_is_jump_s = 1'b1;
            wr_ctr_s     = 2'b11;
         end else if (ex_hit_s) begin
            wr_ctr_en_s  = 1'b1;
            wr_ctr_s     = ctr_step(ctr_r[ex_idx_s], taken_s);
         end else if (taken_s) begin
            wr_full_s    = 1'b1;
            wr_is_jump_s = 1'b0;
            wr_ctr_s     = 2'b10;
         end else begin
            wr_full_s    = 1'b0;
         end
      end else begin
         wr_full_s = 1'b0;
      end
   end

   // BTB storage with synchronous clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            valid_r[i]   <= 1'b0;
            tag_r[i]     <= '0;
            target_r[i]  <= 32'd0;
            is_jump_r[i] <= 1'b0;
            ctr_r[i]     <= CTR_INIT;
            par_r[i]     <= 1'b0;
         end
      end else if (wr_full_s) begin
         valid_r[ex_idx_s]   <= 1'b1;
         tag_r[ex_idx_s]     <= ex_tag_s;
         target_r[ex_idx_s]  <= wr_target_s;
         is_jump_r[ex_idx_s] <= wr_is_jump_s;
         ctr_r[ex_idx_s]     <= wr_ctr_s;
         par_r[ex_idx_s]     <= entry_parity(ex_tag_s, wr_target_s, wr_is_jump_s);
      end else if (wr_ctr_en_s) begin
         ctr_r[ex_idx_s] <= wr_ctr_s;
      end
   end

   // Redirect pulse; the refetch address holds between pulses.
   always_ff @(posedge clk) begin
      if (!reset) begin
         redirect_r    <= 1'b0;
         redirect_pc_r <= 32'd0;
      end else if (mispredict_s) begin
         redirect_r    <= 1'b1;
         redirect_pc_r <= redirect_pc_next_s;
      end else begin
         redirect_r    <= 1'b0;
      end
   end

   assign Redirect    = redirect_r;
   assign Redirect_PC = redirect_pc_r;

`ifdef BP_STATS_EN
   logic [31:0] stat_branches_r;
   logic [31:0] stat_mispredicts_r;

   // Saturating event counters.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stat_branches_r    <= 32'd0;
         stat_mispredicts_r <= 32'd0;
      end else begin
         if (update_s && (stat_branches_r != 32'hFFFF_FFFF)) begin
            stat_branches_r <= stat_branches_r + 32'd1;
         end
         if (mispredict_s && (stat_mispredicts_r != 32'hFFFF_FFFF)) begin
            stat_mispredicts_r <= stat_mispredicts_r + 32'd1;
         end
      end
   end

   assign Stat_Branches    = stat_branches_r;
   assign Stat_Mispredicts = stat_mispredicts_r;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (default parameters).
module tb_branch_predict_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [8:0]  F_PC;
   logic        Pred_Taken;
   logic [31:0] Pred_Target;
   logic        Ex_Valid;
   logic [8:0]  Ex_PC;
   logic [31:0] Imm;
   logic        Branch;
   logic        Jump;
   logic        JumpReg;
   logic [31:0] AluResult;
   logic        Ex_Pred_Taken;
   logic [31:0] Ex_Pred_Target;
   logic [31:0] PC_Imm;
   logic [31:0] PC_Four;
   logic        Redirect;
   logic [31:0] Redirect_PC;
`ifdef BP_STATS_EN
   logic [31:0] Stat_Branches;
   logic [31:0] Stat_Mispredicts;
`endif

   int checks = 0;
   int errors = 0;

   branch_predict_unit dut (
      .clk            (clk),
      .reset          (reset),
      .F_PC           (F_PC),
      .Pred_Taken     (Pred_Taken),
      .Pred_Target    (Pred_Target),
      .Ex_Valid       (Ex_Valid),
      .Ex_PC          (Ex_PC),
      .Imm            (Imm),
      .Branch         (Branch),
      .Jump           (Jump),
      .JumpReg        (JumpReg),
      .AluResult      (AluResult),
      .Ex_Pred_Taken  (Ex_Pred_Taken),
      .Ex_Pred_Target (Ex_Pred_Target),
      .PC_Imm         (PC_Imm),
      .PC_Four        (PC_Four),
      .Redirect       (Redirect),
      .Redirect_PC    (Redirect_PC)
`ifdef BP_STATS_EN
      ,
      .Stat_Branches  (Stat_Branches),
      .Stat_Mispredicts (Stat_Mispredicts)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ex();
      Ex_Valid = 1'b0; Ex_PC = 9'h000; Imm = 32'd0;
      Branch = 1'b0; Jump = 1'b0; JumpReg = 1'b0;
      AluResult = 32'd0; Ex_Pred_Taken = 1'b0; Ex_Pred_Target = 32'd0;
   endtask

   task automatic drive_ex(input logic [8:0] pc, input logic br, input logic j, input logic jr,
                           input logic [31:0] alu, input logic [31:0] imm,
                           input logic ptk, input logic [31:0] ptg);
      Ex_Valid = 1'b1; Ex_PC = pc; Branch = br; Jump = j; JumpReg = jr;
      AluResult = alu; Imm = imm; Ex_Pred_Taken = ptk; Ex_Pred_Target = ptg;
   endtask

   initial begin
      clear_ex();
      F_PC  = 9'h000;
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;

      // 1: reset state and idle
      F_PC = 9'h040;
      #1;
      check("rst_pred_taken", 32'(Pred_Taken), 32'd0);
      check("rst_pred_target", Pred_Target, 32'd0);
      check("rst_redirect", 32'(Redirect), 32'd0);
      check("rst_redirect_pc", Redirect_PC, 32'd0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("idle_redirect", 32'(Redirect), 32'd0);
      end

      // 2: first taken branch mispredicts and allocates
      drive_ex(9'h040, 1'b1, 1'b0, 1'b0, 32'd1, 32'h20, 1'b0, 32'd0);
      #1;
      check("t2_pc_imm", PC_Imm, 32'h60);
      check("t2_pc_four", PC_Four, 32'h44);
      check("t2_same_cycle_old", 32'(Pred_Taken), 32'd0);
      tick();
      clear_ex();
      #1;
      check("t2_redirect", 32'(Redirect), 32'd1);
      check("t2_redirect_pc", Redirect_PC, 32'h60);
      check("t2_pred_taken", 32'(Pred_Taken), 32'd1);
      check("t2_pred_target", Pred_Target, 32'h60);
      tick();
      check("t2_pulse_end", 32'(Redirect), 32'd0);
      check("t2_pc_hold", Redirect_PC, 32'h60);

      // 3: three not-taken resolves, counter 10 -> 01 -> 00 -> 00
      drive_ex(9'h040, 1'b1, 1'b0, 1'b0, 32'd0, 32'h20, 1'b1, 32'h60);
      tick();
      clear_ex();
      #1;
      check("t3a_redirect", 32'(Redirect), 32'd1);
      check("t3a_redirect_pc", Redirect_PC, 32'h44);
      check("t3a_pred_taken", 32'(Pred_Taken), 32'd0);
      drive_ex(9'h040, 1'b1, 1'b0, 1'b0, 32'd0, 32'h20, 1'b0, 32'd0);
      tick();
      clear_ex();
      #1;
      check("t3b_redirect", 32'(Redirect), 32'd0);
      check("t3b_pred_taken", 32'(Pred_Taken), 32'd0);
      drive_ex(9'h040, 1'b1, 1'b0, 1'b0, 32'd0, 32'h20, 1'b0, 32'd0);
      tick();
      clear_ex();
      #1;
      check("t3c_redirect", 32'(Redirect), 32'd0);
      check("t3c_pred_saturated", 32'(Pred_Taken), 32'd0);
      check("t3c_pc_hold", Redirect_PC, 32'h44);

      // 4: JALR target with bit0 cleared
      drive_ex(9'h044, 1'b0, 1'b0, 1'b1, 32'h0000_0103, 32'd4, 1'b1, 32'h100);
      #1;
      check("t4_pc_imm", PC_Imm, 32'h48);
      check("t4_pc_four", PC_Four, 32'h48);
      tick();
      clear_ex();
      F_PC = 9'h044;
      #1;
      check("t4_redirect", 32'(Redirect), 32'd1);
      check("t4_redirect_pc", Redirect_PC, 32'h106);
      check("t4_pred_taken", 32'(Pred_Taken), 32'd1);
      check("t4_pred_target", Pred_Target, 32'h106);

      // 4b: correctly predicted JAL gives no redirect but still allocates
      drive_ex(9'h048, 1'b0, 1'b1, 1'b0, 32'd0, 32'h10, 1'b1, 32'h58);
      tick();
      clear_ex();
      F_PC = 9'h048;
      #1;
      check("t4b_redirect", 32'(Redirect), 32'd0);
      check("t4b_pc_hold", Redirect_PC, 32'h106);
      check("t4b_pred_taken", 32'(Pred_Taken), 32'd1);
      check("t4b_pred_target", Pred_Target, 32'h58);

      // 4c: JumpReg takes priority over Jump
      drive_ex(9'h04C, 1'b0, 1'b1, 1'b1, 32'h200, 32'd8, 1'b1, 32'h54);
      tick();
      clear_ex();
      F_PC = 9'h04C;
      #1;
      check("t4c_redirect", 32'(Redirect), 32'd1);
      check("t4c_redirect_pc", Redirect_PC, 32'h208);
      check("t4c_pred_target", Pred_Target, 32'h208);

      // 5: two taken branches retrain 0x040 (00 -> 01 -> 10), then alias at 0x080
      drive_ex(9'h040, 1'b1, 1'b0, 1'b0, 32'd1, 32'h20, 1'b0, 32'd0);
      tick();
      clear_ex();
      F_PC = 9'h040;
      #1;
      check("t5a_redirect", 32'(Redirect), 32'd1);
      check("t5a_pred_taken", 32'(Pred_Taken), 32'd0);
      drive_ex(9'h040, 1'b1, 1'b0, 1'b0, 32'd1, 32'h20, 1'b0, 32'd0);
      tick();
      clear_ex();
      #1;
      check("t5b_pred_taken", 32'(Pred_Taken), 32'd1);
      check("t5b_pred_target", Pred_Target, 32'h60);
      F_PC = 9'h080;
      #1;
      check("t5_alias_taken", 32'(Pred_Taken), 32'd0);
      check("t5_alias_target", Pred_Target, 32'd0);
      drive_ex(9'h080, 1'b1, 1'b0, 1'b0, 32'd1, 32'h20, 1'b0, 32'd0);
      F_PC = 9'h040;
      #1;
      check("t5_same_cycle_taken", 32'(Pred_Taken), 32'd1);
      check("t5_same_cycle_target", Pred_Target, 32'h60);
      tick();
      clear_ex();
      F_PC = 9'h080;
      #1;
      check("t5_new_taken", 32'(Pred_Taken), 32'd1);
      check("t5_new_target", Pred_Target, 32'hA0);
      check("t5_redirect_pc", Redirect_PC, 32'hA0);
      F_PC = 9'h040;
      #1;
      check("t5_evicted", 32'(Pred_Taken), 32'd0);

      // 6: Ex_Valid=0 suppresses everything
      Ex_Valid = 1'b0; Ex_PC = 9'h050; Branch = 1'b1; AluResult = 32'd1;
      Imm = 32'h20; Ex_Pred_Taken = 1'b0; Ex_Pred_Target = 32'd0;
      tick();
      F_PC = 9'h050;
      #1;
      check("t6_invalid_redirect", 32'(Redirect), 32'd0);
      check("t6_invalid_pc_hold", Redirect_PC, 32'hA0);
      check("t6_invalid_no_alloc", 32'(Pred_Taken), 32'd0);

      // 6b: reset coincides with a mispredict
      Ex_Valid = 1'b1;
      reset    = 1'b0;
      tick();
      reset = 1'b1;
      clear_ex();
      #1;
      check("t6_rst_redirect", 32'(Redirect), 32'd0);
      check("t6_rst_redirect_pc", Redirect_PC, 32'd0);
      check("t6_rst_050", 32'(Pred_Taken), 32'd0);
      F_PC = 9'h044;
      #1;
      check("t6_rst_044", 32'(Pred_Taken), 32'd0);
      F_PC = 9'h048;
      #1;
      check("t6_rst_048", 32'(Pred_Taken), 32'd0);
      F_PC = 9'h080;
      #1;
      check("t6_rst_080", 32'(Pred_Taken), 32'd0);
      check("t6_rst_target", Pred_Target, 32'd0);
`ifdef BP_STATS_EN
      check("t6_stat_branches", Stat_Branches, 32'd0);
      check("t6_stat_mispredicts", Stat_Mispredicts, 32'd0);
`endif
      tick();
      check("t6_post_rst_redirect", 32'(Redirect), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised successor to the EX-stage branch resolver. Adds a fetch-side predictor: a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters. Resolves branch, jump and jump-register outcomes in EX, compares them against the prediction carried down the pipe, and issues a registered redirect on mispredict. Sits between the IF PC mux and the EX stage.

Parameters:
PC_W, 9, PC width in bits; PCs are zero-extended to 32 for arithmetic.
ENTRIES, 16, BTB/counter depth; power of two, 2..256; IDX_W = log2(ENTRIES).
CTR_INIT, 2'b01, counter reset value (01 = weakly not-taken).

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
F_PC  in  PC_W  fetch PC to predict
Pred_Taken  out  1  combinational: predict taken for F_PC
Pred_Target  out  32  combinational: predicted target; 0 when Pred_Taken=0
Ex_Valid  in  1  EX instruction valid; gates all updates
Ex_PC  in  PC_W  PC of the EX instruction
Imm  in  32  immediate
Branch  in  1  conditional branch
Jump  in  1  JAL
JumpReg  in  1  JALR
AluResult  in  32  bit0 is the branch condition; full value is the JALR base
Ex_Pred_Taken  in  1  prediction made for this instruction at fetch
Ex_Pred_Target  in  32  target predicted at fetch
PC_Imm  out  32  combinational: Ex_PC + Imm
PC_Four  out  32  combinational: Ex_PC + 4
Redirect  out  1  registered one-cycle pulse: flush and refetch
Redirect_PC  out  32  registered: refetch address, valid while Redirect=1

Behaviour:
- Indexing: idx = PC[IDX_W+1:2]. tag = PC[PC_W-1:IDX_W+2]. Tag width must be at least 1; parameters violating this are an elaboration error.
- Each entry holds: valid, tag, 32-bit target, is_jump, 2-bit counter.
- Lookup is combinational. hit = valid && tag match. Pred_Taken = hit && (is_jump || ctr[1]). Pred_Target = entry target when Pred_Taken=1, else 0.
- EX actual outcome:
  - taken = (Branch && AluResult[0]) || Jump || JumpReg.
  - target = {AluResult[31:1],1'b0} + Imm when JumpReg, else PC_Imm.
  - All arithmetic is modulo 2^32.
- mispredict = Ex_Valid && (taken != Ex_Pred_Taken || (taken && target != Ex_Pred_Target)).
- Redirect is registered with latency 1: the cycle after mispredict, Redirect=1 and Redirect_PC = taken ? target : PC_Four. Otherwise Redirect=0 and Redirect_PC holds its last value.
- Update on the clock edge when Ex_Valid && (Branch||Jump||JumpReg):
  - Conditional branch: if the entry hits, the counter increments (taken) or decrements (not taken), saturating at 11 and 00.
  - Conditional branch, taken, miss: allocate the entry with valid=1, new tag, target, is_jump=0, ctr=2'b10.
  - Conditional branch, not taken, miss: no write.
  - Jump/JumpReg: always allocate or overwrite with valid=1, target, is_jump=1, ctr=2'b11.
- Multiple flags set at once: priority is JumpReg > Jump > Branch.
- Ex_Valid=0: no update and no Redirect, regardless of the other inputs.
- Same-cycle lookup and update to the same idx: the lookup returns the pre-update contents (write-first is forbidden).
- Reset (reset=0 at a clock edge), including mid-operation:
  - All valid bits cleared; all counters set to CTR_INIT.
  - Redirect=0, Redirect_PC=0.
  - Pred_Taken=0 for every F_PC on the following cycle.
  - A mispredict present in the reset cycle is dropped.

Optional Feature:
BP_STATS_EN:
- When defined, adds outputs Stat_Branches[31:0] and Stat_Mispredicts[31:0].
- Stat_Branches counts valid EX instructions that update the table.
- Stat_Mispredicts counts mispredict cycles.
- Both counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Reset, then F_PC=9'h040 -> Pred_Taken=0, Pred_Target=0; Redirect=0 for 5 idle cycles.
2. EX: Ex_PC=0x040, Branch=1, AluResult=1, Imm=0x20, Ex_Pred_Taken=0 -> PC_Imm=0x60, PC_Four=0x44, next cycle Redirect=1 with Redirect_PC=0x60 for exactly one cycle. Then F_PC=0x040 -> Pred_Taken=1, Pred_Target=0x60.
3. Three not-taken resolves at 0x040, each with correct Ex_Pred_* -> counter 10→01→00→00; Pred_Taken=0 after the first. Redirect pulses only for resolves whose prediction was taken.
4. JumpReg=1, AluResult=0x0000_0103, Imm=4, Ex_Pred_Taken=1, Ex_Pred_Target=0x100 -> target=0x106, Redirect=1, Redirect_PC=0x106.
5. Alias: taken branch at 0x040, then fetch 0x080 (same idx=0, different tag) -> Pred_Taken=0. Update and lookup of the same idx in one cycle -> old value returned.
6. Ex_Valid=0 with Branch=1 and AluResult=1 -> no Redirect, no table change. Assert reset while Redirect is pending -> Redirect stays 0 and the table clears; with BP_STATS_EN defined, both stats read 0.
